pz_term_evaluator: RTL and testbench
====================================

Name: pz_term_evaluator

Overview:
- Upstream stage of pz_accumulator. For one log-frequency point, computes the Bode-magnitude asymptote contribution of every pole/zero corner.
- Iterates sequentially over corner entries, one per cycle, into a shadow register file.
- Commits the whole file atomically as `flat_pz`, which drives pz_accumulator's `flat_pz` input directly.
- Also latches the `no_z`/`no_p` counts, so the downstream sum always matches the committed data.

Parameters:
- REG_FILE_SIZE, 2: number of pole/zero entries (N).
- DATA_SIZE, 16: signed width of log-frequency, corners and terms.
- LOG_FRAC, 8: fractional bits. 1 decade = 2^LOG_FRAC log units; dB output uses the same Q format.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request evaluation; sampled only in IDLE
- log_f  in  DATA_SIZE  signed log10 frequency, Q(.LOG_FRAC)
- flat_corner  in  DATA_SIZE*REG_FILE_SIZE  signed corner log-frequencies; entry i = [DATA_SIZE*i +: DATA_SIZE]; zeros first, then poles
- no_z  in  32  zero count
- no_p  in  32  pole count
- busy  out  1  high while evaluating
- flat_pz_valid  out  1  one-cycle pulse when `flat_pz` has been committed
- flat_pz  out  DATA_SIZE*REG_FILE_SIZE  committed term file; feeds pz_accumulator `flat_pz`
- no_z_q  out  32  zero count latched at start, published at commit
- no_p_q  out  32  pole count latched at start, published at commit

Behaviour:
- Reset (async assert, rst_n=0): state=IDLE, index=0, busy=0, flat_pz_valid=0, flat_pz=0, shadow=0, no_z_q=0, no_p_q=0.
- States:
  - IDLE: on start=1, capture log_f, flat_corner, no_z, no_p and active=min(no_z+no_p, N). Set index=0, busy=1, go to EVAL. With start=0, hold.
  - EVAL: each cycle write shadow[index]=term(index), then index+1. When index==N-1, go to COMMIT.
  - COMMIT: flat_pz<=shadow, no_z_q/no_p_q<=captured counts, flat_pz_valid=1 for exactly this cycle, busy=0, go to IDLE.
- Latency: with start sampled at edge k, the EVAL edges are k+1..k+N and COMMIT is edge k+N+1. flat_pz and flat_pz_valid change on edge k+N+1; busy is high from edge k+1 to edge k+N+1.
- Fixed cost: every job walks all N entries regardless of the active count. It takes N+1 cycles after the start edge.
- Term for entry i:
  - i >= active: term = 0.
  - Otherwise d = log_f - corner_i, computed at DATA_SIZE+1 bits.
  - d <= 0: term = 0.
  - d > 0: term = d*20, saturated to 2^(DATA_SIZE-1)-1. Terms are never negative.
- Sign convention belongs downstream: pz_accumulator subtracts the pole terms, so this block always emits magnitudes.
- Intermediate width: the product is DATA_SIZE+6 bits signed. No wrap-around is permitted anywhere.
- Input capture: all inputs are captured at start. Changes to inputs during busy have no effect.
- start while busy: ignored, no queueing. start on the COMMIT cycle is also ignored; the next accepted start is in IDLE.
- flat_pz stability: flat_pz holds its value between commits. Only atomic updates are allowed; no partial file is ever visible.
- Downstream timing: pz_accumulator registers its sum, so acc_pz is valid one clock after flat_pz_valid.
- Count clamping: if no_z+no_p > N, active clamps to N and no_z_q/no_p_q pass through unmodified. Guarding the downstream loop bound is the integrator's responsibility.
- Reset mid-EVAL: abort immediately to the reset values. The previously committed flat_pz is cleared to 0, and no valid pulse is emitted.

Decomposition:
- Shared package pz_pkg:
  - state enum {IDLE, EVAL, COMMIT}
  - constant SLOPE_DB = 20
  - saturation helper for signed to DATA_SIZE
- Sub-module pz_term_calc (combinational): inputs log_f, corner, enable; output term. Covers difference, clamp-at-zero, multiply by SLOPE_DB and saturate.
- The FSM, index counter, capture and shadow registers live in pz_term_evaluator.

Test Plan:
- Nominal: N=2, LOG_FRAC=8, corners {0, 256}, log_f=512, no_z=1, no_p=1, one start pulse. Required: entry0=10240, entry1=5120, valid pulse exactly 3 cycles after the start edge, and downstream acc_pz=5120 one cycle later.
- Below corner: corners {600, 1000}, log_f=512. Required: flat_pz = {0, 0}; with the equal-corner case log_f=600, entry0 = 0.
- Saturation: log_f=32767, corner0=-32768, no_z=1, no_p=0. Required: entry0=32767 and entry1=0 (inactive).
- Busy behaviour: start held high for 5 cycles with log_f changing each cycle. Required: exactly one job, using the log_f from the accepted cycle; a second job starts on the first IDLE cycle; flat_pz never shows a partial update.
- Clamp: no_z=2, no_p=3, N=2. Required: both entries computed, no_z_q=2, no_p_q=3, no out-of-range access.
- Reset mid-EVAL: assert rst_n=0 on the cycle after start. Required: busy=0, valid never pulses, flat_pz=0; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/pz_pkg.sv
// Shared types and helpers for the pole/zero asymptote term evaluator.
package pz_pkg;

    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} pz_state_t;

    localparam int SLOPE_DB = 20;

    // Clamp a wide signed value into the range of a w-bit signed word.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pz_term_calc.sv
// Combinational Bode-asymptote term for one corner: 20 dB/decade above the
// corner, zero at or below it, saturated to the signed output range.
module pz_term_calc
    import pz_pkg::*;
#(
    parameter int DATA_SIZE = 16
) (
    input  logic signed [DATA_SIZE-1:0] log_f,
    input  logic signed [DATA_SIZE-1:0] corner,
    input  logic                        enable,
    output logic signed [DATA_SIZE-1:0] term
);

    localparam int DW = DATA_SIZE + 1;
    localparam int PW = DATA_SIZE + 6;

    logic signed [DW-1:0] diff;
    logic signed [PW-1:0] prod;

    // One extra bit keeps the difference exact; six more hold the x20 product.
    always_comb begin
        diff = DW'(log_f) - DW'(corner);
        prod = PW'(diff) * PW'(SLOPE_DB);
        term = '0;
        if (enable && (diff > 0))
            term = DATA_SIZE'(sat_signed(64'(prod), DATA_SIZE));
    end

endmodule

// File: rtl/pz_term_evaluator.sv
// Walks every pole/zero corner for one log-frequency point into a shadow file
// and publishes the whole file, with its counts, in a single commit cycle.
module pz_term_evaluator
    import pz_pkg::*;
#(
    parameter int REG_FILE_SIZE = 2,
    parameter int DATA_SIZE     = 16,
    parameter int LOG_FRAC      = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic signed [DATA_SIZE-1:0]        log_f,
    input  logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_corner,
    input  logic [31:0]                        no_z,
    input  logic [31:0]                        no_p,
    output logic                               busy,
    output logic                               flat_pz_valid,
    output logic [DATA_SIZE*REG_FILE_SIZE-1:0] flat_pz,
    output logic [31:0]                        no_z_q,
    output logic [31:0]                        no_p_q
);

    localparam int N  = REG_FILE_SIZE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = DATA_SIZE * N;

    if (LOG_FRAC >= DATA_SIZE) begin : g_bad_q_format
        $error("LOG_FRAC must leave at least one integer bit in DATA_SIZE");
    end

    pz_state_t                   state;
    logic [IW-1:0]               index;
    logic signed [DATA_SIZE-1:0] log_f_c;
    logic [FW-1:0]               corner_c;
    logic [31:0]                 no_z_c;
    logic [31:0]                 no_p_c;
    logic [31:0]                 active_c;
    logic [FW-1:0]               shadow;

    logic [32:0]                 cnt_sum;
    logic [31:0]                 active_next;
    logic signed [DATA_SIZE-1:0] corner_sel;
    logic                        term_en;
    logic signed [DATA_SIZE-1:0] term;

    // The 33-bit sum keeps huge counts from wrapping below N.
    assign cnt_sum     = {1'b0, no_z} + {1'b0, no_p};
    assign active_next = (cnt_sum > 33'(N)) ? 32'(N) : cnt_sum[31:0];
    assign corner_sel  = corner_c[DATA_SIZE*index +: DATA_SIZE];
    assign term_en     = 32'(index) < active_c;

    pz_term_calc #(
        .DATA_SIZE(DATA_SIZE)
    ) u_term (
        .log_f (log_f_c),
        .corner(corner_sel),
        .enable(term_en),
        .term  (term)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            index         <= '0;
            busy          <= 1'b0;
            flat_pz_valid <= 1'b0;
            flat_pz       <= '0;
            shadow        <= '0;
            no_z_q        <= '0;
            no_p_q        <= '0;
            log_f_c       <= '0;
            corner_c      <= '0;
            no_z_c        <= '0;
            no_p_c        <= '0;
            active_c      <= '0;
        end else begin
            flat_pz_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        log_f_c  <= log_f;
                        corner_c <= flat_corner;
                        no_z_c   <= no_z;
                        no_p_c   <= no_p;
                        active_c <= active_next;
                        index    <= '0;
                        busy     <= 1'b1;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    shadow[DATA_SIZE*index +: DATA_SIZE] <= term;
                    if (index == IW'(N - 1)) begin
                        state <= COMMIT;
                    end else begin
                        index <= index + IW'(1);
                    end
                end
                COMMIT: begin
                    flat_pz       <= shadow;
                    no_z_q        <= no_z_c;
                    no_p_q        <= no_p_c;
                    flat_pz_valid <= 1'b1;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pz_term_evaluator.sv
// Table-driven and scoreboard bench for pz_term_evaluator with a small
// downstream accumulator model.
module tb_pz_term_evaluator;

    localparam int N  = 2;
    localparam int DS = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic signed [15:0] log_f;
    logic [31:0]        flat_corner;
    logic [31:0]        no_z;
    logic [31:0]        no_p;
    logic               busy;
    logic               flat_pz_valid;
    logic [31:0]        flat_pz;
    logic [31:0]        no_z_q;
    logic [31:0]        no_p_q;

    pz_term_evaluator #(
        .REG_FILE_SIZE(N),
        .DATA_SIZE    (DS),
        .LOG_FRAC     (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .log_f        (log_f),
        .flat_corner  (flat_corner),
        .no_z         (no_z),
        .no_p         (no_p),
        .busy         (busy),
        .flat_pz_valid(flat_pz_valid),
        .flat_pz      (flat_pz),
        .no_z_q       (no_z_q),
        .no_p_q       (no_p_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lf;
        int          c0;
        int          c1;
        logic [31:0] nz;
        logic [31:0] np;
        int          e0;
        int          e1;
        int          acc;
    } vec_t;

    typedef struct {
        logic [31:0] pz;
        logic [31:0] nz;
        logic [31:0] np;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [31:0] last_pz = '0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_valid = 0;
    int          acc_pz = 0;
    vec_t        tbl[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_term(input int lf, input int c, input bit en);
        int d;
        if (!en) return 0;
        d = lf - c;
        if (d <= 0) return 0;
        d = d * 20;
        return (d > 32767) ? 32767 : d;
    endfunction

    function automatic logic [31:0] pack(input int e0, input int e1);
        return {e1[15:0], e0[15:0]};
    endfunction

    function automatic int acc_model(input logic [31:0] pz, input logic [31:0] nz, input logic [31:0] np);
        int s;
        logic signed [15:0] t;
        s = 0;
        for (int i = 0; i < N; i++) begin
            t = pz[16*i +: 16];
            if (longint'(i) < longint'(nz) + longint'(np))
                s += (longint'(i) < longint'(nz)) ? int'(t) : -int'(t);
        end
        return s;
    endfunction

    // Downstream pz_accumulator stand-in: registers the signed sum on commit.
    always @(posedge clk) begin
        if (flat_pz_valid) acc_pz <= acc_model(flat_pz, no_z_q, no_p_q);
    end

    always @(negedge clk) begin
        if (flat_pz_valid) begin
            n_valid++;
            if (sbq.size() == 0) begin
                check("unexpected_valid", longint'(flat_pz_valid), 0);
            end else begin
                mon_e = sbq.pop_front();
                check("flat_pz", flat_pz, mon_e.pz);
                check("no_z_q", no_z_q, mon_e.nz);
                check("no_p_q", no_p_q, mon_e.np);
                last_pz = mon_e.pz;
            end
        end else begin
            check("flat_pz_hold", flat_pz, last_pz);
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   lat;
        @(negedge clk);
        log_f       = 16'(v.lf);
        flat_corner = {16'(v.c1), 16'(v.c0)};
        no_z        = v.nz;
        no_p        = v.np;
        start       = 1'b1;
        e.pz = pack(v.e0, v.e1);
        e.nz = v.nz;
        e.np = v.np;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start       = 1'b0;
        log_f       = 16'($urandom);
        flat_corner = $urandom;
        no_z        = $urandom;
        no_p        = $urandom;
        check("busy_after_start", longint'(busy), 1);
        lat = 0;
        while (!flat_pz_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("valid_latency", lat, 3);
        check("busy_at_commit", longint'(busy), 0);
        @(negedge clk);
        check("valid_pulse_width", longint'(flat_pz_valid), 0);
        check("acc_pz", acc_pz, v.acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   v0;
        int   lf;
        int   c0;
        int   c1;
        int   w;

        tbl[0] = '{512, 0, 256, 32'd1, 32'd1, 10240, 5120, 5120};
        tbl[1] = '{512, 600, 1000, 32'd1, 32'd1, 0, 0, 0};
        tbl[2] = '{600, 600, 1000, 32'd1, 32'd1, 0, 0, 0};
        tbl[3] = '{32767, -32768, 0, 32'd1, 32'd0, 32767, 0, 32767};
        tbl[4] = '{512, 0, 256, 32'd2, 32'd3, 10240, 5120, 15360};
        tbl[5] = '{300, 256, 200, 32'd0, 32'd1, 880, 0, -880};
        tbl[6] = '{0, 0, 0, 32'd0, 32'd0, 0, 0, 0};
        tbl[7] = '{-100, -200, -32768, 32'd1, 32'd1, 2000, 32767, -30767};
        tbl[8] = '{1, 0, -1, 32'd0, 32'd2, 20, 40, -60};
        tbl[9] = '{10, 0, 5, 32'hFFFF_FFFF, 32'd2, 200, 100, 300};

        rst_n       = 1'b0;
        start       = 1'b0;
        log_f       = '0;
        flat_corner = '0;
        no_z        = '0;
        no_p        = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_valid", longint'(flat_pz_valid), 0);
        check("rst_flat_pz", flat_pz, 0);
        check("rst_no_z_q", no_z_q, 0);
        check("rst_no_p_q", no_p_q, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        // start held for five cycles: jobs accepted on cycle 0 and cycle 4 only.
        v0 = n_valid;
        @(negedge clk);
        no_z  = 32'd1;
        no_p  = 32'd1;
        start = 1'b1;
        for (int j = 0; j < 5; j++) begin
            lf    = 400 + 37 * j;
            log_f = 16'(lf);
            if (j == 0) begin
                c0 = 0;
                c1 = 256;
            end else if (j == 4) begin
                c0 = 50;
                c1 = 100;
            end else begin
                c0 = -30000;
                c1 = -30000;
            end
            flat_corner = {16'(c1), 16'(c0)};
            if (j == 0 || j == 4) begin
                e.pz = pack(model_term(lf, c0, 1'b1), model_term(lf, c1, 1'b1));
                e.nz = 32'd1;
                e.np = 32'd1;
                sbq.push_back(e);
            end
            @(posedge clk);
            @(negedge clk);
            if (j == 3) check("busy_low_after_commit", longint'(busy), 0);
            if (j == 4) check("busy_second_job", longint'(busy), 1);
        end
        start = 1'b0;
        w = 0;
        while (sbq.size() != 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);
        check("held_start_jobs", n_valid - v0, 2);
        check("held_start_sbq_empty", sbq.size(), 0);

        // Reset asserted during EVAL aborts the job and clears the committed file.
        @(negedge clk);
        log_f       = 16'sd512;
        flat_corner = {16'sd256, 16'sd0};
        no_z        = 32'd1;
        no_p        = 32'd1;
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_busy", longint'(busy), 1);
        #2;
        rst_n = 1'b0;
        sbq.delete();
        last_pz = '0;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_valid", longint'(flat_pz_valid), 0);
        check("midrst_flat_pz", flat_pz, 0);
        check("midrst_no_z_q", no_z_q, 0);
        v0 = n_valid;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_pulse", n_valid - v0, 0);
        run_vec(tbl[0]);
        run_vec(tbl[3]);

        repeat (2) @(negedge clk);
        check("final_sbq_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
